// File: rtl/btn_press_classifier.sv
// Turns a debounced button level into short-press, long-press and auto-repeat
// single-cycle events, plus a busy flag while a press is being timed.
module btn_press_classifier #(
    parameter int unsigned MIN_CYCLES    = 500,
    parameter int unsigned LONG_CYCLES   = 15000,
    parameter int unsigned REPEAT_CYCLES = 5000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic boton_in,
    output logic pulso_corto,
    output logic pulso_largo,
    output logic pulso_rep,
    output logic ocupado
);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam bit               REP_ON = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {
        ESPERA_SUELTA,
        REPOSO,
        PRESION,
        LARGO
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] rep_cnt, rep_nx;
    logic             corto_nx, largo_nx, rep_pulse_nx, ocupado_nx;

    // State, counters and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ESPERA_SUELTA;
            cnt         <= '0;
            rep_cnt     <= '0;
            pulso_corto <= 1'b0;
            pulso_largo <= 1'b0;
            pulso_rep   <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rep_cnt     <= rep_nx;
            pulso_corto <= corto_nx;
            pulso_largo <= largo_nx;
            pulso_rep   <= rep_pulse_nx;
            ocupado     <= ocupado_nx;
        end
    end

    // Next state and next-cycle event decisions
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rep_nx       = rep_cnt;
        corto_nx     = 1'b0;
        largo_nx     = 1'b0;
        rep_pulse_nx = 1'b0;

        case (state)
            ESPERA_SUELTA: begin
                if (!boton_in) begin
                    state_nx = REPOSO;
                end
            end
            REPOSO: begin
                if (boton_in) begin
                    state_nx = PRESION;
                    cnt_nx   = ONE_C;
                end
            end
            PRESION: begin
                if (boton_in) begin
                    cnt_nx = cnt + ONE_C;
                    if (cnt + ONE_C == LONG_C) begin
                        largo_nx = 1'b1;
                        rep_nx   = '0;
                        state_nx = LARGO;
                    end
                end else begin
                    state_nx = REPOSO;
                    corto_nx = (cnt >= MIN_C) && (cnt < LONG_C);
                end
            end
            LARGO: begin
                if (boton_in) begin
                    if (REP_ON) begin
                        if (rep_cnt + ONE_C == REP_C) begin
                            rep_pulse_nx = 1'b1;
                            rep_nx       = '0;
                        end else begin
                            rep_nx = rep_cnt + ONE_C;
                        end
                    end
                end else begin
                    state_nx = REPOSO;
                end
            end
            default: begin
                state_nx = ESPERA_SUELTA;
            end
        endcase

        ocupado_nx = (state_nx == PRESION) || (state_nx == LARGO);
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier using scaled timing parameters,
// with a second instance built with auto-repeat disabled.
module tb_btn_press_classifier;

    localparam int MIN_C  = 5;
    localparam int LONG_C = 150;
    localparam int REP_C  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boton = 1'b0;
    logic pulso_corto, pulso_largo, pulso_rep, ocupado;
    logic pulso_corto0, pulso_largo0, pulso_rep0, ocupado0;

    always #10 clk = ~clk;

    btn_press_classifier #(
        .MIN_CYCLES(MIN_C), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .boton_in(boton),
        .pulso_corto(pulso_corto), .pulso_largo(pulso_largo),
        .pulso_rep(pulso_rep), .ocupado(ocupado)
    );

    btn_press_classifier #(
        .MIN_CYCLES(MIN_C), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(0), .CNT_W(24)
    ) dut0 (
        .clk(clk), .rst(rst), .boton_in(boton),
        .pulso_corto(pulso_corto0), .pulso_largo(pulso_largo0),
        .pulso_rep(pulso_rep0), .ocupado(ocupado0)
    );

    typedef struct {
        int len;
        int corto;
        int corto_len;
        int largo;
        int largo_h;
        int rep;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int h = 0;
    int n_corto, n_largo, n_rep, n_ocu, largo_h, corto_len;
    int n_corto0, n_largo0, n_rep0, n_ocu0;
    int rep_h[$];
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        n_corto = 0; n_largo = 0; n_rep = 0; n_ocu = 0;
        n_corto0 = 0; n_largo0 = 0; n_rep0 = 0; n_ocu0 = 0;
        largo_h = 0; corto_len = 0;
        rep_h.delete();
    endtask

    // One clock: drive, let the edge happen, then record what it decided
    task automatic cyc(input logic b, input logic r);
        int prev;
        boton = b;
        rst   = r;
        @(posedge clk);
        #1;
        prev = h;
        if (r) h = 0;
        else if (b) h = h + 1;
        else h = 0;
        if (pulso_corto) begin n_corto++; corto_len = prev; end
        if (pulso_largo) begin n_largo++; largo_h = h; end
        if (pulso_rep) begin n_rep++; rep_h.push_back(h); end
        n_ocu    += int'(ocupado);
        n_corto0 += int'(pulso_corto0);
        n_largo0 += int'(pulso_largo0);
        n_rep0   += int'(pulso_rep0);
        n_ocu0   += int'(ocupado0);
        checks++;
        if (int'(pulso_corto) + int'(pulso_largo) + int'(pulso_rep) > 1) begin
            errors++;
            $display("FAIL one_hot actual=%b%b%b required=at most one", pulso_corto,
                     pulso_largo, pulso_rep);
        end
    endtask

    task automatic press(input int len);
        for (int i = 0; i < len; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{len: 100, corto: 1, corto_len: 100, largo: 0, largo_h: 0,   rep: 0};
        vecs[1] = '{len: 299, corto: 0, corto_len: 0,   largo: 1, largo_h: 150, rep: 2};
        vecs[2] = '{len: 4,   corto: 0, corto_len: 0,   largo: 0, largo_h: 0,   rep: 0};
        vecs[3] = '{len: 5,   corto: 1, corto_len: 5,   largo: 0, largo_h: 0,   rep: 0};
        vecs[4] = '{len: 149, corto: 1, corto_len: 149, largo: 0, largo_h: 0,   rep: 0};
        vecs[5] = '{len: 150, corto: 0, corto_len: 0,   largo: 1, largo_h: 150, rep: 0};
        vecs[6] = '{len: 1,   corto: 0, corto_len: 0,   largo: 0, largo_h: 0,   rep: 0};
        vecs[7] = '{len: 200, corto: 0, corto_len: 0,   largo: 1, largo_h: 150, rep: 1};

        clr();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        chk("rst_corto", int'(pulso_corto), 0);
        chk("rst_largo", int'(pulso_largo), 0);
        chk("rst_rep", int'(pulso_rep), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        chk("idle_ocupado", int'(ocupado), 0);

        // Latency of ocupado and pulso_corto around a single press
        clr();
        cyc(1'b1, 1'b0);
        chk("ocu_rise", int'(ocupado), 1);
        for (int i = 0; i < 19; i++) cyc(1'b1, 1'b0);
        chk("ocu_held", int'(ocupado), 1);
        cyc(1'b0, 1'b0);
        chk("corto_latency", int'(pulso_corto), 1);
        chk("ocu_fall", int'(ocupado), 0);
        cyc(1'b0, 1'b0);
        chk("corto_single", int'(pulso_corto), 0);

        for (int v = 0; v < 8; v++) begin
            clr();
            press(vecs[v].len);
            chk($sformatf("v%0d_corto", v), n_corto, vecs[v].corto);
            chk($sformatf("v%0d_corto_len", v), corto_len, vecs[v].corto_len);
            chk($sformatf("v%0d_largo", v), n_largo, vecs[v].largo);
            chk($sformatf("v%0d_largo_h", v), largo_h, vecs[v].largo_h);
            chk($sformatf("v%0d_rep", v), n_rep, vecs[v].rep);
            for (int k = 0; k < rep_h.size(); k++)
                chk($sformatf("v%0d_rep_h%0d", v, k), rep_h[k], LONG_C + (k + 1) * REP_C);
            chk($sformatf("v%0d_ocu_cycles", v), n_ocu, vecs[v].len);
            chk($sformatf("v%0d_norep_largo", v), n_largo0, vecs[v].largo);
            chk($sformatf("v%0d_norep_rep", v), n_rep0, 0);
        end

        // A one-sample low gap splits the press into two short counts
        clr();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        press(4);
        chk("gap_short_corto", n_corto, 0);
        chk("gap_short_ocu", n_ocu, 8);
        clr();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        press(5);
        chk("gap_valid_corto", n_corto, 2);
        chk("gap_valid_len", corto_len, 5);

        // Button held through reset stays silent until released
        clr();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0);
        chk("held_ocu", n_ocu, 0);
        chk("held_corto", n_corto, 0);
        chk("held_largo", n_largo, 0);
        chk("held_rep", n_rep, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("held_release_corto", n_corto, 0);
        press(10);
        chk("rearm_corto", n_corto, 1);
        chk("rearm_len", corto_len, 10);

        // Reset in the middle of a long press
        clr();
        for (int i = 0; i < 160; i++) cyc(1'b1, 1'b0);
        chk("mid_largo", n_largo, 1);
        chk("mid_ocu_before", int'(ocupado), 1);
        cyc(1'b1, 1'b1);
        chk("mid_rst_ocu", int'(ocupado), 0);
        chk("mid_rst_pulses",
            int'(pulso_corto) + int'(pulso_largo) + int'(pulso_rep), 0);
        clr();
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0);
        chk("mid_after_rep", n_rep, 0);
        chk("mid_after_largo", n_largo, 0);
        chk("mid_after_ocu", n_ocu, 0);
        cyc(1'b0, 1'b0);
        chk("mid_release_corto", n_corto, 0);
        press(10);
        chk("mid_rearm_corto", n_corto, 1);

        // Long hold: repeat instance vs. repeat-disabled instance
        clr();
        press(400);
        chk("long_largo", n_largo, 1);
        chk("long_rep", n_rep, 5);
        chk("long_corto", n_corto, 0);
        chk("norep_largo", n_largo0, 1);
        chk("norep_rep", n_rep0, 0);
        chk("norep_corto", n_corto0, 0);
        chk("norep_ocu", n_ocu0, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
